// File: rtl/skinny_tbc_round_ctrl.sv
// skinny_tbc_round_ctrl: iterative round sequencer for SKINNY-128-384.
// Holds the state/TK1/TK2/TK3 working registers, drives them into an
// external combinational round datapath together with numrnd round
// constants per cycle, and registers the datapath results back until all
// ROUNDS rounds are done.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a new block; start loads the working registers
//   RUN   | numrnd rounds applied per cycle, start ignored
//   DONE  | one-cycle done pulse with state_out valid, then IDLE
module skinny_tbc_round_ctrl #(
  parameter int numrnd  = 2,
  parameter int fullcnt = 1,
  parameter int ROUNDS  = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [127:0]               key_in,
  input  logic [127:0]               tweak_in,
  input  logic [64+64*fullcnt-1:0]   cnt_in,
  input  logic [127:0]               state_in,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [127:0]               state_out,
  output logic [127:0]               roundkey,
  output logic [127:0]               roundtweak,
  output logic [64+64*fullcnt-1:0]   roundcnt,
  output logic [127:0]               roundstate,
  output logic [6*numrnd-1:0]        constant,
  input  logic [127:0]               nextkey,
  input  logic [127:0]               nexttweak,
  input  logic [64+64*fullcnt-1:0]   nextcnt,
  input  logic [127:0]               nextstate
);

  localparam int CW = 64 + 64 * fullcnt;
  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] RND_STEP = RW'(numrnd);
  localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t            fsm_q;
  logic [5:0]      rc_q;
  logic [RW-1:0]   rnd_q;
  logic [RW-1:0]   rnd_next;
  logic [127:0]    key_q;
  logic [127:0]    tweak_q;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    state_q;
  logic [5:0]      rc_last;

  // one step of the 6-bit SKINNY round-constant LFSR
  function automatic logic [5:0] lfsr_step(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4] ^ 1'b1};
  endfunction

  // constants for this cycle: slice i is rc advanced i+1 times
  always_comb begin
    logic [5:0] v;
    constant = '0;
    v = rc_q;
    for (int i = 0; i < numrnd; i++) begin
      v = lfsr_step(v);
      constant[6*i +: 6] = v;
    end
    rc_last = v;
  end

  assign rnd_next = rnd_q + RND_STEP;

  assign roundkey   = key_q;
  assign roundtweak = tweak_q;
  assign roundcnt   = cnt_q;
  assign roundstate = state_q;

  // sequencer: working registers, round counter, LFSR and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      state_out <= '0;
      key_q     <= '0;
      tweak_q   <= '0;
      cnt_q     <= '0;
      state_q   <= '0;
      rc_q      <= '0;
      rnd_q     <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= state_in;
            cnt_q   <= cnt_in;
            tweak_q <= tweak_in;
            key_q   <= key_in;
            rc_q    <= '0;
            rnd_q   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= nextstate;
          cnt_q   <= nextcnt;
          tweak_q <= nexttweak;
          key_q   <= nextkey;
          rc_q    <= rc_last;
          rnd_q   <= rnd_next;
          // equality compare ends the run, so the counter never wraps
          if (rnd_next == RND_LAST) begin
            state_out <= nextstate;
            busy      <= 1'b0;
            done      <= 1'b1;
            fsm_q     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          fsm_q <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          fsm_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_tbc_round_ctrl.sv
// tb_skinny_tbc_round_ctrl: drives the controller with a stand-in
// combinational round datapath and compares against a round-by-round
// reference computed from the LFSR constant sequence.
module tb_skinny_tbc_round_ctrl;

  localparam int NRND = 2;
  localparam int NCYC = 40 / NRND;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in, tweak_in, cnt_in, state_in;
  logic         ready, busy, done;
  logic [127:0] state_out, roundkey, roundtweak, roundcnt, roundstate;
  logic [11:0]  constant;
  logic [127:0] nextkey, nexttweak, nextcnt, nextstate;

  int checks = 0;
  int failures = 0;
  logic [5:0] seq [0:40];

  skinny_tbc_round_ctrl #(.numrnd(NRND), .fullcnt(1), .ROUNDS(40)) dut (
    .clk(clk), .rst(rst), .start(start),
    .key_in(key_in), .tweak_in(tweak_in), .cnt_in(cnt_in), .state_in(state_in),
    .ready(ready), .busy(busy), .done(done), .state_out(state_out),
    .roundkey(roundkey), .roundtweak(roundtweak), .roundcnt(roundcnt),
    .roundstate(roundstate), .constant(constant),
    .nextkey(nextkey), .nexttweak(nexttweak), .nextcnt(nextcnt),
    .nextstate(nextstate)
  );

  always #5 clk = ~clk;

  // stand-in for numrnd unrolled rounds: mixes every register and constant
  function automatic logic [127:0] dp_state(input logic [127:0] s, k, t, c,
                                            input logic [11:0] cst);
    return {s[126:0], s[127]} ^ k ^ t ^ c ^ {116'd0, cst};
  endfunction

  always_comb begin
    nextstate = dp_state(roundstate, roundkey, roundtweak, roundcnt, constant);
    nextkey   = roundkey + 128'd3;
    nexttweak = {roundtweak[0], roundtweak[127:1]};
    nextcnt   = roundcnt + 128'd1;
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // reference: ROUNDS/numrnd datapath applications with consecutive LFSR pairs
  function automatic logic [127:0] model_enc(input logic [127:0] s, k, t, c);
    for (int j = 0; j < NCYC; j++) begin
      s = dp_state(s, k, t, c, {seq[2*j+2], seq[2*j+1]});
      k = k + 128'd3;
      t = {t[0], t[127:1]};
      c = c + 128'd1;
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // one encryption; returns the negedge index (after the start edge) of done
  task automatic run_enc(input logic [127:0] s, k, t, c, input bit chk_const,
                         output int n_done);
    @(negedge clk);
    state_in = s; key_in = k; tweak_in = t; cnt_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = -1;
    for (int n = 1; n <= 60; n++) begin
      if (chk_const && busy)
        chk("constant", {116'd0, constant}, {116'd0, seq[2*n], seq[2*n-1]});
      if (done) begin
        n_done = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [127:0] s, k, t, c;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int nd, t1, t2, pulses;
    logic [127:0] k0;

    seq[0] = 6'h00;
    for (int i = 1; i <= 40; i++)
      seq[i] = {seq[i-1][4:0], seq[i-1][5] ^ seq[i-1][4] ^ 1'b1};

    for (int i = 0; i < 8; i++) begin
      vecs[i].s = rand128(); vecs[i].k = rand128();
      vecs[i].t = rand128(); vecs[i].c = rand128();
      vecs[i].exp = model_enc(vecs[i].s, vecs[i].k, vecs[i].t, vecs[i].c);
    end

    rst = 1'b1; start = 1'b0;
    key_in = '0; tweak_in = '0; cnt_in = '0; state_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {127'd0, ready}, 128'd1);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_state_out", state_out, 128'd0);
    chk("rst_roundstate", roundstate, 128'd0);
    chk("rst_constant", {116'd0, constant}, 128'h0C1);

    // first block: constant sequence, done timing, pulse width, ready return
    run_enc(vecs[0].s, vecs[0].k, vecs[0].t, vecs[0].c, 1'b1, nd);
    chk("done_latency", nd, 21);
    chk("cipher_0", state_out, vecs[0].exp);
    chk("done_busy_low", {127'd0, busy}, 128'd0);
    @(negedge clk);
    chk("done_width", {127'd0, done}, 128'd0);
    chk("ready_after_done", {127'd0, ready}, 128'd1);
    chk("state_out_held", state_out, vecs[0].exp);

    for (int i = 1; i < 8; i++) begin
      run_enc(vecs[i].s, vecs[i].k, vecs[i].t, vecs[i].c, 1'b0, nd);
      chk("vec_latency", nd, 21);
      chk("vec_cipher", state_out, vecs[i].exp);
    end

    // start held high: one block per 22 cycles, no reload mid-run
    @(negedge clk);
    vecs[0].s = rand128(); k0 = rand128();
    vecs[0].t = rand128(); vecs[0].c = rand128();
    vecs[0].exp = model_enc(vecs[0].s, k0, vecs[0].t, vecs[0].c);
    state_in = vecs[0].s; key_in = k0; tweak_in = vecs[0].t; cnt_in = vecs[0].c;
    start = 1'b1;
    t1 = -1; t2 = -1; pulses = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 5) begin
        key_in = ~k0; state_in = rand128();
      end
      if (n == 6) chk("no_reload_key", roundkey, k0 + 128'd15);
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          t1 = n;
          chk("held_cipher", state_out, vecs[0].exp);
          state_in = rand128();
        end else begin
          t2 = n;
          break;
        end
      end
    end
    start = 1'b0;
    chk("held_period", t2 - t1, 22);
    @(negedge clk);
    chk("held_ready", {127'd0, ready}, 128'd1);

    // reset at RUN cycle 10 aborts without a done pulse
    state_in = vecs[1].s; key_in = vecs[1].k; tweak_in = vecs[1].t; cnt_in = vecs[1].c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", {127'd0, busy}, 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {127'd0, ready}, 128'd1);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_state_out", state_out, 128'd0);
    chk("abort_roundkey", roundkey, 128'd0);
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_idle_ready", {127'd0, ready}, 128'd1);
    run_enc(vecs[2].s, vecs[2].k, vecs[2].t, vecs[2].c, 1'b1, nd);
    chk("post_abort_latency", nd, 21);
    chk("post_abort_cipher", state_out, vecs[2].exp);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
